// File: rtl/btn_event_conditioner_pkg.sv
// Shared definitions for the button event conditioner: debounce FSM state
// encoding, default 25 MHz timing constants and channel index names.
// Optional feature macro: BTN_EVENT_REPEAT_EN (auto-repeat of press pulses).
package btn_event_conditioner_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } deb_state_t;

  // Defaults for a 25 MHz vgaclk
  localparam int DEF_NBTN       = 5;
  localparam int DEF_DEB_CYCLES = 250000;    // 10 ms
  localparam int DEF_CNT_W      = 18;
  localparam int DEF_REP_DELAY  = 12500000;  // 500 ms
  localparam int DEF_REP_PERIOD = 2500000;   // 100 ms
  localparam int DEF_REP_W      = 24;

  // Board button positions on btn_raw
  localparam int BTN_C = 0;
  localparam int BTN_E = 1;
  localparam int BTN_W = 2;
  localparam int BTN_N = 3;
  localparam int BTN_S = 4;

endpackage

// File: rtl/btn_event_conditioner_if.sv
// Button bus: raw inputs toward the conditioner, conditioned events back.
// master = consumer side (drives raw buttons), slave = the conditioner.
interface btn_event_conditioner_if #(
  parameter int NBTN = 5
);
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_press;
  logic [NBTN-1:0] btn_release;
  logic            any_press;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, any_press
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, any_press
  );
endinterface

// File: rtl/btn_event_chan.sv
// One button channel: 2-flop synchroniser, stability-counter debounce FSM,
// registered level/press/release, and (with BTN_EVENT_REPEAT_EN) auto-repeat
// press pulses while the button is held.
// press_nxt is the value press takes on the next edge; the top uses it to
// register any_press in the same cycle as the per-channel pulses.
// DEB_CYCLES is expected to be at least 2.
module btn_event_chan
  import btn_event_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD,
  parameter int REP_W      = DEF_REP_W
) (
  input  logic vgaclk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic press_nxt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic       sync_meta;
  logic       sync;
  deb_state_t state;
  logic [CNT_W-1:0] cnt;
  logic       settle;
  logic       rep_hit;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  // The new level has been seen for DEB_CYCLES consecutive cycles: accept it
  assign settle = (state == ST_CHANGING) && (sync != level) && (cnt == CNT_LAST);

`ifdef BTN_EVENT_REPEAT_EN
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REP_DELAY - REP_PERIOD);

  logic [REP_W-1:0] rcnt;

  // An accepted release wins over a repeat landing on the same edge, so
  // press and release never coincide.
  assign rep_hit = level && !settle && (rcnt == REP_LAST);

  // Hold timer: restarts on any accepted edge, runs while the level is high;
  // reloading to DELAY-PERIOD makes every later hit one PERIOD apart.
  always_ff @(posedge vgaclk) begin
    if (reset || settle || !level)
      rcnt <= '0;
    else if (rep_hit)
      rcnt <= REP_RELOAD;
    else
      rcnt <= rcnt + 1'b1;
  end
`else
  assign rep_hit = 1'b0;
`endif

  assign press_nxt = (settle && !level) || rep_hit;

  // Debounce FSM with registered level and one-cycle press/release pulses
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= press_nxt;
      rel   <= settle && level;
      case (state)
        ST_STABLE: begin
          if (sync != level) begin
            state <= ST_CHANGING;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        ST_CHANGING: begin
          if (sync == level) begin
            // bounce back to the old level: discard the partial count
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_STABLE;
            cnt   <= '0;
            level <= ~level;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_event_conditioner.sv
// Multi-channel button front end: NBTN independent debounce channels whose
// outputs are gathered onto the button bus, plus a registered any_press.
// Optional feature macro: BTN_EVENT_REPEAT_EN (auto-repeat while held).
module btn_event_conditioner
  import btn_event_conditioner_pkg::*;
#(
  parameter int NBTN       = DEF_NBTN,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD,
  parameter int REP_W      = DEF_REP_W
) (
  input  logic                   vgaclk,
  input  logic                   reset,
  btn_event_conditioner_if.slave bus
);

  logic [NBTN-1:0] level_v;
  logic [NBTN-1:0] press_v;
  logic [NBTN-1:0] rel_v;
  logic [NBTN-1:0] press_nxt_v;
  logic            any_q;

  for (genvar g = 0; g < NBTN; g++) begin : g_chan
    btn_event_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W),
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD),
      .REP_W      (REP_W)
    ) u_chan (
      .vgaclk    (vgaclk),
      .reset     (reset),
      .raw       (bus.btn_raw[g]),
      .level     (level_v[g]),
      .press     (press_v[g]),
      .rel       (rel_v[g]),
      .press_nxt (press_nxt_v[g])
    );
  end

  // any_press registered from the channels' next-press terms so it rises
  // on the same edge as the btn_press bits it summarises
  always_ff @(posedge vgaclk) begin
    if (reset) any_q <= 1'b0;
    else       any_q <= |press_nxt_v;
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = rel_v;
  assign bus.any_press   = any_q;

endmodule

// File: tb/tb_btn_event_conditioner.sv
// Bench for btn_event_conditioner with short timing (DEB_CYCLES=4,
// REP_DELAY=10, REP_PERIOD=3). A run-length reference model tracks every
// channel; scenario tasks compare the DUT against it and against directed
// timing expectations.
module tb_btn_event_conditioner;
  import btn_event_conditioner_pkg::*;

  localparam int NBTN = 5, DEB = 4, CNT_W = 3, RD = 10, RP = 3, REP_W = 5;

  logic vgaclk = 1'b0;
  logic reset  = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  btn_event_conditioner_if #(.NBTN(NBTN)) bus();

  btn_event_conditioner #(
    .NBTN(NBTN), .DEB_CYCLES(DEB), .CNT_W(CNT_W),
    .REP_DELAY(RD), .REP_PERIOD(RP), .REP_W(REP_W)
  ) dut (
    .vgaclk (vgaclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 vgaclk = ~vgaclk;

  // Reference model: raw is seen two edges late; a level flips once the
  // seen value has disagreed with it DEB times in a row. With repeat, held
  // buttons pulse at RD, RD+RP, ... cycles after the accepted press.
  logic [NBTN-1:0] m_d1, m_d2, m_level, m_press, m_rel;
  logic            m_any;
  int              m_run [NBTN];
  int              m_hold[NBTN];

  always @(posedge vgaclk) begin : model
    logic [NBTN-1:0] nl, np, nr;
    if (reset) begin
      m_d1 <= '0; m_d2 <= '0; m_level <= '0; m_press <= '0; m_rel <= '0; m_any <= 1'b0;
      for (int i = 0; i < NBTN; i++) begin
        m_run[i]  <= 0;
        m_hold[i] <= 0;
      end
    end else begin
      nl = m_level; np = '0; nr = '0;
      for (int i = 0; i < NBTN; i++) begin
        int run, hold;
        run = (m_d2[i] != m_level[i]) ? m_run[i] + 1 : 0;
        if (run == DEB) begin
          nl[i] = ~m_level[i];
          np[i] = nl[i];
          nr[i] = ~nl[i];
          run   = 0;
        end
        hold = m_hold[i];
`ifdef BTN_EVENT_REPEAT_EN
        if (np[i] || nr[i]) hold = 0;
        else if (m_level[i]) begin
          hold = hold + 1;
          if (hold >= RD && (hold - RD) % RP == 0) np[i] = 1'b1;
        end
`endif
        m_run[i]  <= run;
        m_hold[i] <= hold;
      end
      m_d1 <= bus.btn_raw; m_d2 <= m_d1;
      m_level <= nl; m_press <= np; m_rel <= nr; m_any <= |np;
    end
  end

  task automatic tick();
    @(posedge vgaclk);
    @(negedge vgaclk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.btn_raw = 5'b10110;
    repeat (3) tick();
    n_checks++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !== 16'h0)
      $display("FAIL reset_outputs: got %b %b %b %b want all zero",
               bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press);
    bus.btn_raw = '0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_idle: got %b %b %b want zero", bus.btn_level, bus.btn_press, bus.btn_release);
      end
    end
  endtask

  task automatic test_single_press();
    bus.btn_raw[BTN_C] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      logic e;
      e = (i == 6);
      tick();
      n_checks++;
      if ({bus.btn_press[BTN_C], bus.any_press, bus.btn_level[BTN_C]} !== {e, e, logic'(i >= 6)}) begin
        n_fail++;
        $display("FAIL single_press cyc%0d: got p=%b any=%b lvl=%b want p=%b any=%b lvl=%b",
                 i, bus.btn_press[BTN_C], bus.any_press, bus.btn_level[BTN_C], e, e, i >= 6);
      end
    end
    bus.btn_raw[BTN_C] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !==
          {m_level, m_press, m_rel, m_any}) begin
        n_fail++;
        $display("FAIL single_release_model: got %b %b %b want %b %b %b",
                 bus.btn_level, bus.btn_press, bus.btn_release, m_level, m_press, m_rel);
      end
    end
  endtask

  task automatic test_bounce();
    int bseq[6] = '{1, 0, 1, 1, 0, 1};
    int early = 0, total = 0;
    for (int i = 0; i < 18; i++) begin
      bus.btn_raw[BTN_E] = (i < 6) ? bseq[i][0] : 1'b1;
      tick();
      if (bus.btn_press[BTN_E]) begin
        total++;
        if (i < 6) early++;
      end
      n_checks++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL bounce_model cyc%0d: got %b %b %b want %b %b %b", i,
                 bus.btn_level, bus.btn_press, bus.btn_release, m_level, m_press, m_rel);
      end
    end
    n_checks++;
    if (early !== 0 || total !== 1) begin
      n_fail++;
      $display("FAIL bounce_pulses: got early=%0d total=%0d want early=0 total=1", early, total);
    end
    bus.btn_raw[BTN_E] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_release();
    bus.btn_raw[BTN_W] = 1'b1;
    repeat (10) tick();
    bus.btn_raw[BTN_W] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if ({bus.btn_release[BTN_W], bus.btn_press[BTN_W], bus.btn_level[BTN_W]} !==
          {logic'(i == 6), 1'b0, logic'(i < 6)}) begin
        n_fail++;
        $display("FAIL release cyc%0d: got rel=%b p=%b lvl=%b want rel=%b p=0 lvl=%b",
                 i, bus.btn_release[BTN_W], bus.btn_press[BTN_W], bus.btn_level[BTN_W], i == 6, i < 6);
      end
    end
  endtask

  task automatic test_simultaneous();
    bus.btn_raw[BTN_S:BTN_N] = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if ({bus.btn_press, bus.any_press} !== {((i == 6) ? 5'b11000 : 5'b00000), logic'(i == 6)}) begin
        n_fail++;
        $display("FAIL simultaneous cyc%0d: got press=%b any=%b want press=%b any=%b",
                 i, bus.btn_press, bus.any_press, (i == 6) ? 5'b11000 : 5'b00000, i == 6);
      end
    end
    bus.btn_raw = '0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid_count();
    bus.btn_raw[BTN_C] = 1'b1;
    repeat (4) tick();            // count has reached 2
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({bus.btn_press, bus.btn_level, bus.any_press} !== 11'h0) begin
        n_fail++;
        $display("FAIL reset_mid_hold: got press=%b lvl=%b want 0", bus.btn_press, bus.btn_level);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if ({bus.btn_press[BTN_C], bus.btn_level[BTN_C]} !== {logic'(i == 6), logic'(i >= 6)}) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc%0d: got p=%b lvl=%b want p=%b lvl=%b",
                 i, bus.btn_press[BTN_C], bus.btn_level[BTN_C], i == 6, i >= 6);
      end
    end
    bus.btn_raw = '0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    int pulses = 0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NBTN; c++)
        if ($urandom_range(9, 0) < 2) bus.btn_raw[c] = ~bus.btn_raw[c];
      tick();
      pulses += $countones(bus.btn_press) + $countones(bus.btn_release);
      n_checks++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !==
          {m_level, m_press, m_rel, m_any}) begin
        n_fail++;
        $display("FAIL random_model cyc%0d: got %b %b %b %b want %b %b %b %b", i,
                 bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press,
                 m_level, m_press, m_rel, m_any);
      end
      n_checks++;
      if ((bus.btn_press & bus.btn_release) !== '0) begin
        n_fail++;
        $display("FAIL random_overlap: got press=%b release=%b want disjoint", bus.btn_press, bus.btn_release);
      end
    end
    bus.btn_raw = '0;
    repeat (10) tick();
  endtask

`ifdef BTN_EVENT_REPEAT_EN
  task automatic test_repeat();
    int found = 0, late = 0;
    bus.btn_raw[BTN_C] = 1'b1;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (bus.btn_press[BTN_C]) found = 1;
    end
    n_checks++;
    if (found !== 1) begin
      n_fail++;
      $display("FAIL repeat_accept: got no press within 20 cycles want one");
    end
    for (int k = 1; k <= 30; k++) begin
      logic e;
      e = (k >= RD) && ((k - RD) % RP == 0);
      tick();
      n_checks++;
      if (bus.btn_press[BTN_C] !== e) begin
        n_fail++;
        $display("FAIL repeat_pulse +%0d: got %b want %b", k, bus.btn_press[BTN_C], e);
      end
    end
    bus.btn_raw[BTN_C] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.btn_level[BTN_C] && bus.btn_press[BTN_C]) late++;
    end
    n_checks++;
    if (late !== 0 || bus.btn_level[BTN_C] !== 1'b0) begin
      n_fail++;
      $display("FAIL repeat_after_release: got %0d pulses lvl=%b want 0 pulses lvl=0", late, bus.btn_level[BTN_C]);
    end
  endtask
`endif

  initial begin
    bus.btn_raw = '0;
    test_reset();
    test_single_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
`ifdef BTN_EVENT_REPEAT_EN
    test_repeat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
